draw_sched: RTL

Command scheduler for the VGA drawing engines. Accepts queued draw commands (screen fill or circle), starts the matching engine (`fillscreen` or `circle`) with a held start/done handshake, and routes only the active engine's pixel stream to the single VGA adapter plot port. Sits between the top-level command source and the two engines.

---
 rtl/draw_pkg.sv | 28 ++
 rtl/draw_cmd_fifo.sv | 44 ++++
 rtl/draw_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared types and screen geometry for the draw command scheduler.
// Optional feature macro used by draw_sched: DRAW_SCHED_CLIP_EN.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_CIRC = 1'b1
    } draw_op_t;

    typedef struct packed {
        draw_op_t    op;
        logic [2:0]  colour;
        logic [7:0]  cx;
        logic [6:0]  cy;
        logic [7:0]  radius;
    } draw_cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_FILL = 2'd1,
        RUN_CIRC = 2'd2,
        RELEASE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Show-ahead command FIFO: the head entry is visible combinationally so the
// scheduler can pop it into its command register on the same edge.
module draw_cmd_fifo
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  draw_cmd_t push_data,
    input  logic      pop,
    output draw_cmd_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    draw_cmd_t   mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/draw_sched.sv
// Draw command scheduler: queues fill/circle commands, runs one engine at a
// time with a held start/done handshake and muxes its pixels to the VGA port.
// Optional: define DRAW_SCHED_CLIP_EN to suppress off-screen plots.
module draw_sched
    import draw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [2:0] cmd_colour,
    input  logic [7:0] cmd_cx,
    input  logic [6:0] cmd_cy,
    input  logic [7:0] cmd_radius,
    output logic       fill_start,
    output logic [2:0] fill_colour,
    input  logic       fill_done,
    input  logic       fill_vga_plot,
    input  logic [7:0] fill_vga_x,
    input  logic [6:0] fill_vga_y,
    input  logic [2:0] fill_vga_colour,
    output logic       circ_start,
    output logic [7:0] circ_centre_x,
    output logic [6:0] circ_centre_y,
    output logic [7:0] circ_radius,
    output logic [2:0] circ_colour,
    input  logic       circ_done,
    input  logic       circ_vga_plot,
    input  logic [7:0] circ_vga_x,
    input  logic [6:0] circ_vga_y,
    input  logic [2:0] circ_vga_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       cmd_done,
    output logic       busy
);

    draw_state_t state_reg, state_next;
    draw_cmd_t   cur_reg;
    draw_cmd_t   push_cmd;
    draw_cmd_t   head;
    logic        fifo_full, fifo_empty;
    logic        push, pop;
    logic        fill_start_reg, circ_start_reg, cmd_done_reg;
    logic        active_done;
    logic        plot_raw;

    always_comb begin
        push_cmd        = '0;
        push_cmd.op     = draw_op_t'(cmd_op);
        push_cmd.colour = cmd_colour;
        push_cmd.cx     = cmd_cx;
        push_cmd.cy     = cmd_cy;
        push_cmd.radius = cmd_radius;
    end

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state_reg == IDLE) && !fifo_empty;

    draw_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The running command's op selects whose done we listen to, also in RELEASE.
    assign active_done = (cur_reg.op == OP_CIRC) ? circ_done : fill_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cur_reg        <= '0;
            fill_start_reg <= 1'b0;
            circ_start_reg <= 1'b0;
            cmd_done_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            if (pop) cur_reg <= head;
            fill_start_reg <= (state_next == RUN_FILL);
            circ_start_reg <= (state_next == RUN_CIRC);
            cmd_done_reg   <= (state_reg == RELEASE) && !active_done;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty)
                    state_next = (head.op == OP_CIRC) ? RUN_CIRC : RUN_FILL;
            end
            RUN_FILL, RUN_CIRC: begin
                if (active_done) state_next = RELEASE;
            end
            RELEASE: begin
                if (!active_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fill_start    = fill_start_reg;
        circ_start    = circ_start_reg;
        cmd_done      = cmd_done_reg;
        fill_colour   = cur_reg.colour;
        circ_colour   = cur_reg.colour;
        circ_centre_x = cur_reg.cx;
        circ_centre_y = cur_reg.cy;
        circ_radius   = cur_reg.radius;
        busy          = (state_reg != IDLE) || !fifo_empty;
        vga_x         = '0;
        vga_y         = '0;
        vga_colour    = '0;
        plot_raw      = 1'b0;
        if (state_reg != IDLE) begin
            if (cur_reg.op == OP_CIRC) begin
                vga_x      = circ_vga_x;
                vga_y      = circ_vga_y;
                vga_colour = circ_vga_colour;
                plot_raw   = circ_vga_plot;
            end else begin
                vga_x      = fill_vga_x;
                vga_y      = fill_vga_y;
                vga_colour = fill_vga_colour;
                plot_raw   = fill_vga_plot;
            end
        end
    end

`ifdef DRAW_SCHED_CLIP_EN
    assign vga_plot = plot_raw && (vga_x < 8'(SCREEN_W)) && (vga_y < 7'(SCREEN_H));
`else
    assign vga_plot = plot_raw;
`endif

endmodule
